// File: rtl/pact_lsu_port_arbiter_if.sv
// Bundle of port-side request/response, cache access, and cache control signals for the PACT LSU arbiter.
// slave = arbiter view, master = the surrounding LSU/cache view.
interface pact_lsu_port_arbiter_if #(
    parameter int NUM_PORT = 4,
    parameter int BW_ADDR  = 32,
    parameter int BW_DATA  = 32,
    parameter int BW_CMD   = 4
);
    localparam int BW_STRB = BW_DATA / 8;

    logic [NUM_PORT-1:0]              port_qvalid;
    logic [NUM_PORT-1:0]              port_qready;
    logic [NUM_PORT-1:0]              port_qwrite;
    logic [NUM_PORT-1:0][BW_ADDR-1:0] port_qaddr;
    logic [NUM_PORT-1:0][BW_DATA-1:0] port_qwdata;
    logic [NUM_PORT-1:0][BW_STRB-1:0] port_qwstrb;
    logic [NUM_PORT-1:0]              port_yvalid;
    logic [NUM_PORT-1:0]              port_yready;
    logic [NUM_PORT-1:0][BW_DATA-1:0] port_ydata;

    logic               acc_qvalid, acc_qready, acc_qwrite;
    logic [BW_ADDR-1:0] acc_qaddr;
    logic [BW_DATA-1:0] acc_qwdata;
    logic [BW_STRB-1:0] acc_qwstrb;
    logic               acc_yvalid, acc_yready;
    logic [BW_DATA-1:0] acc_ydata;

    logic               ctrl_valid, ctrl_ready, ctrl_done;
    logic [BW_CMD-1:0]  ctrl_cmd;
    logic [BW_ADDR-1:0] ctrl_base, ctrl_last;

    logic               cache_control_valid, cache_control_ready, cache_control_busy;
    logic [BW_CMD-1:0]  cache_control_command;
    logic [BW_ADDR-1:0] cache_control_base, cache_control_last;
    logic               busy;

    modport slave (
        input  port_qvalid, port_qwrite, port_qaddr, port_qwdata, port_qwstrb, port_yready,
        input  acc_qready, acc_yvalid, acc_ydata,
        input  ctrl_valid, ctrl_cmd, ctrl_base, ctrl_last,
        input  cache_control_ready, cache_control_busy,
        output port_qready, port_yvalid, port_ydata,
        output acc_qvalid, acc_qwrite, acc_qaddr, acc_qwdata, acc_qwstrb, acc_yready,
        output ctrl_ready, ctrl_done,
        output cache_control_valid, cache_control_command, cache_control_base, cache_control_last,
        output busy
    );

    modport master (
        output port_qvalid, port_qwrite, port_qaddr, port_qwdata, port_qwstrb, port_yready,
        output acc_qready, acc_yvalid, acc_ydata,
        output ctrl_valid, ctrl_cmd, ctrl_base, ctrl_last,
        output cache_control_ready, cache_control_busy,
        input  port_qready, port_yvalid, port_ydata,
        input  acc_qvalid, acc_qwrite, acc_qaddr, acc_qwdata, acc_qwstrb, acc_yready,
        input  ctrl_ready, ctrl_done,
        input  cache_control_valid, cache_control_command, cache_control_base, cache_control_last,
        input  busy
    );
endinterface

// File: rtl/pact_lsu_port_arbiter.sv
// Merges NUM_PORT load/store streams onto one cache port, returns in-order read data by tag,
// and sequences cache control ops behind a drain of outstanding reads.
module pact_lsu_port_arbiter #(
    parameter int NUM_PORT        = 4,
    parameter int BW_ADDR         = 32,
    parameter int BW_DATA         = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ARB_MODE        = 0,
    parameter int BW_CMD          = 4
) (
    input logic                    clk,
    input logic                    rstpp,
    pact_lsu_port_arbiter_if.slave bus
);
    localparam int BW_STRB = BW_DATA / 8;
    localparam int BW_PORT = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;
    localparam int BW_PTR  = $clog2(MAX_OUTSTANDING);
    localparam int BW_CNT  = BW_PTR + 1;

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_ISSUE, S_WAIT} state_e;
    state_e state_q, state_d;

    logic               pend_q, wr_q;
    logic [BW_PORT-1:0] grant_q, rr_q;
    logic [BW_ADDR-1:0] addr_q;
    logic [BW_DATA-1:0] wdata_q;
    logic [BW_STRB-1:0] wstrb_q;
    logic [BW_PORT-1:0] tag_q [MAX_OUTSTANDING];
    logic [BW_PTR-1:0]  wptr_q, rptr_q;
    logic [BW_CNT-1:0]  cnt_q, cnt_eff;
    logic [BW_CMD-1:0]  cmd_q;
    logic [BW_ADDR-1:0] base_q, last_q;

    logic               acc_hs, push, pop, empty, load_ok, gnt_vld, ctrl_ready;
    logic [BW_PORT-1:0] gnt_idx, head;
    logic [NUM_PORT-1:0] elig;

    assign acc_hs = pend_q & bus.acc_qready;
    assign push   = acc_hs & ~wr_q;
    assign empty  = (cnt_q == '0);
    assign head   = tag_q[rptr_q];
    assign pop    = bus.acc_yvalid & ~empty & bus.port_yready[head];

    // A pop in this cycle frees a slot in time for the load granted now.
    always_comb begin
        int idx;
        idx     = 0;
        cnt_eff = cnt_q - BW_CNT'(pop);
        load_ok = (int'(cnt_eff) < MAX_OUTSTANDING);
        elig    = bus.port_qvalid & (bus.port_qwrite | {NUM_PORT{load_ok}});
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_PORT; k++) begin
            idx = (ARB_MODE == 1) ? k : (int'(rr_q) + k) % NUM_PORT;
            if (!gnt_vld && elig[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = BW_PORT'(idx);
            end
        end
        gnt_vld = gnt_vld & ~pend_q & (state_q == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rstpp) begin
            pend_q  <= 1'b0;
            wr_q    <= 1'b0;
            grant_q <= '0;
            rr_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            cmd_q   <= '0;
            base_q  <= '0;
            last_q  <= '0;
            state_q <= S_IDLE;
        end else begin
            if (acc_hs) pend_q <= 1'b0;
            if (gnt_vld) begin
                pend_q  <= 1'b1;
                grant_q <= gnt_idx;
                wr_q    <= bus.port_qwrite[gnt_idx];
                addr_q  <= bus.port_qaddr[gnt_idx];
                wdata_q <= bus.port_qwdata[gnt_idx];
                wstrb_q <= bus.port_qwstrb[gnt_idx];
                rr_q    <= (int'(gnt_idx) == NUM_PORT - 1) ? '0 : gnt_idx + 1'b1;
            end
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop) rptr_q <= rptr_q + 1'b1;
            cnt_q   <= cnt_q + BW_CNT'(push) - BW_CNT'(pop);
            state_q <= state_d;
            if (ctrl_ready) begin
                cmd_q  <= bus.ctrl_cmd;
                base_q <= bus.ctrl_base;
                last_q <= bus.ctrl_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) tag_q[wptr_q] <= grant_q;
    end

    always_comb begin
        state_d                 = state_q;
        ctrl_ready              = 1'b0;
        bus.cache_control_valid = 1'b0;
        bus.ctrl_done           = 1'b0;
        case (state_q)
            S_IDLE: if (bus.ctrl_valid) begin
                ctrl_ready = 1'b1;
                state_d    = S_DRAIN;
            end
            S_DRAIN: if (!pend_q && empty) state_d = S_ISSUE;
            S_ISSUE: begin
                bus.cache_control_valid = 1'b1;
                if (bus.cache_control_ready) state_d = S_WAIT;
            end
            S_WAIT: if (!bus.cache_control_busy) begin
                bus.ctrl_done = 1'b1;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Read data with no tag outstanding is swallowed rather than stalling the cache.
    always_comb begin
        bus.acc_yready = empty ? bus.acc_yvalid : bus.port_yready[head];
        for (int i = 0; i < NUM_PORT; i++) begin
            bus.port_qready[i] = acc_hs & (grant_q == BW_PORT'(i));
            bus.port_yvalid[i] = bus.acc_yvalid & ~empty & (head == BW_PORT'(i));
            bus.port_ydata[i]  = bus.port_yvalid[i] ? bus.acc_ydata : '0;
        end
    end

    assign bus.acc_qvalid            = pend_q;
    assign bus.acc_qwrite            = wr_q;
    assign bus.acc_qaddr             = addr_q;
    assign bus.acc_qwdata            = wdata_q;
    assign bus.acc_qwstrb            = wstrb_q;
    assign bus.ctrl_ready            = ctrl_ready;
    assign bus.cache_control_command = cmd_q;
    assign bus.cache_control_base    = base_q;
    assign bus.cache_control_last    = last_q;
    assign bus.busy                  = ~empty | (state_q != S_IDLE);
endmodule

// File: tb/tb_pact_lsu_port_arbiter.sv
// Directed bench: round-robin and fixed-priority arbitration, backpressure, tag FIFO full,
// response routing, control-op drain/issue/wait, and mid-operation reset.
`timescale 1ns/1ps
module tb_pact_lsu_port_arbiter;
    localparam int NP = 4;
    localparam logic [31:0] D0 = 32'hD000_0000;

    logic clk = 1'b0;
    logic rstpp = 1'b1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pact_lsu_port_arbiter_if #(.NUM_PORT(NP), .BW_ADDR(32), .BW_DATA(32), .BW_CMD(4)) b1 ();
    pact_lsu_port_arbiter_if #(.NUM_PORT(NP), .BW_ADDR(32), .BW_DATA(32), .BW_CMD(4)) b2 ();

    pact_lsu_port_arbiter #(.NUM_PORT(NP), .BW_ADDR(32), .BW_DATA(32), .MAX_OUTSTANDING(4),
                            .ARB_MODE(0), .BW_CMD(4)) dut_rr (.clk(clk), .rstpp(rstpp), .bus(b1));
    pact_lsu_port_arbiter #(.NUM_PORT(NP), .BW_ADDR(32), .BW_DATA(32), .MAX_OUTSTANDING(4),
                            .ARB_MODE(1), .BW_CMD(4)) dut_fp (.clk(clk), .rstpp(rstpp), .bus(b2));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] addr_of(input int p);
        return 32'h1000 + 32'(p * 16);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        b1.port_qvalid = '0; b1.port_qwrite = '0; b1.port_qaddr = '0; b1.port_qwdata = '0;
        b1.port_qwstrb = '0; b1.port_yready = '0; b1.acc_qready = 0; b1.acc_yvalid = 0;
        b1.acc_ydata = '0; b1.ctrl_valid = 0; b1.ctrl_cmd = '0; b1.ctrl_base = '0; b1.ctrl_last = '0;
        b1.cache_control_ready = 0; b1.cache_control_busy = 0;
        b2.port_qvalid = '0; b2.port_qwrite = '0; b2.port_qaddr = '0; b2.port_qwdata = '0;
        b2.port_qwstrb = '0; b2.port_yready = '0; b2.acc_qready = 0; b2.acc_yvalid = 0;
        b2.acc_ydata = '0; b2.ctrl_valid = 0; b2.ctrl_cmd = '0; b2.ctrl_base = '0; b2.ctrl_last = '0;
        b2.cache_control_ready = 0; b2.cache_control_busy = 0;

        // reset state
        tick; tick;
        chk("rst_outs", {b1.acc_qvalid, b1.port_qready, b1.port_yvalid, b1.acc_yready, b1.ctrl_ready,
                         b1.ctrl_done, b1.cache_control_valid, b1.busy}, '0);
        chk("rst_payload", {b1.acc_qaddr, b1.acc_qwdata}, '0);
        rstpp = 0;

        // round-robin grants with all four ports loading
        for (int i = 0; i < NP; i++) b1.port_qaddr[i] = addr_of(i);
        b1.port_qvalid = 4'hF; b1.acc_qready = 1; b1.port_yready = 4'hF;
        for (int i = 0; i < NP; i++) begin
            tick;
            chk("rr_addr", b1.acc_qaddr, addr_of(i));
            chk("rr_qready", b1.port_qready, 64'd1 << i);
            tick;
        end

        // tag FIFO full: further loads are held off
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("full_block", b1.acc_qvalid, 0);
        end
        chk("full_busy", b1.busy, 1);

        // responses routed in order; a pop lets the blocked load through
        b1.acc_yvalid = 1; b1.acc_ydata = D0; #1;
        chk("rsp0_yvalid", b1.port_yvalid, 4'b0001);
        chk("rsp0_ydata", b1.port_ydata[0], D0);
        chk("rsp0_yready", b1.acc_yready, 1);
        tick;
        b1.port_qvalid = 4'b0001; b1.acc_ydata = D0 + 1; #1;
        chk("full_pop_grant", {b1.acc_qvalid, b1.acc_qaddr}, {1'b1, addr_of(0)});
        chk("rsp1_yvalid", b1.port_yvalid, 4'b0010);
        chk("rsp1_ydata", b1.port_ydata[1], D0 + 1);
        tick;
        b1.port_qvalid = '0; b1.acc_ydata = D0 + 2; #1;
        chk("rsp2_route", {b1.port_yvalid, b1.port_ydata[2]}, {4'b0100, D0 + 2});
        tick;
        b1.acc_ydata = D0 + 3; #1;
        chk("rsp3_route", {b1.port_yvalid, b1.port_ydata[3]}, {4'b1000, D0 + 3});
        tick;
        b1.acc_ydata = D0 + 4; #1;
        chk("rsp4_route", {b1.port_yvalid, b1.port_ydata[0]}, {4'b0001, D0 + 4});
        tick;
        b1.acc_yvalid = 0; #1;
        chk("rsp_drained", b1.busy, 0);

        // backpressure on a store
        b1.acc_qready = 0; b1.port_qvalid = 4'b0100; b1.port_qwrite = 4'b0100;
        b1.port_qaddr[2] = 32'h2000_0040; b1.port_qwdata[2] = 32'hCAFE_F00D; b1.port_qwstrb[2] = 4'b0110;
        tick;
        for (int i = 0; i < 5; i++) begin
            chk("bp_addr", {b1.acc_qvalid, b1.acc_qwrite, b1.acc_qaddr}, {2'b11, 32'h2000_0040});
            chk("bp_wdata", {b1.acc_qwstrb, b1.acc_qwdata}, {4'b0110, 32'hCAFE_F00D});
            chk("bp_noready", b1.port_qready, 0);
            tick;
        end
        b1.acc_qready = 1; #1;
        chk("bp_release", b1.port_qready, 4'b0100);
        tick;
        b1.port_qvalid = '0; b1.port_qwrite = '0; b1.port_qaddr[2] = addr_of(2); #1;
        chk("store_no_tag", {b1.acc_qvalid, b1.busy}, 0);

        // flush with two reads outstanding
        b1.port_qvalid = 4'b0011;
        tick;
        chk("fl_g0", b1.acc_qaddr, addr_of(0));
        tick;
        b1.port_qvalid = 4'b0010;
        tick;
        chk("fl_g1", b1.acc_qaddr, addr_of(1));
        tick;
        b1.port_qvalid = '0;
        b1.ctrl_valid = 1; b1.ctrl_cmd = 4'h5; b1.ctrl_base = 32'h0000_1000; b1.ctrl_last = 32'h0000_1FFF;
        b1.cache_control_ready = 1; #1;
        chk("ctrl_ready", b1.ctrl_ready, 1);
        tick;
        b1.ctrl_valid = 0; #1;
        chk("ctrl_ready_drain", b1.ctrl_ready, 0);
        chk("drain_cmd", {b1.cache_control_command, b1.cache_control_base}, {4'h5, 32'h0000_1000});
        tick;
        chk("drain_hold", {b1.cache_control_valid, b1.busy}, 2'b01);
        b1.acc_yvalid = 1; b1.acc_ydata = 32'hBEEF_0000; #1;
        chk("fl_rsp0", b1.port_yvalid, 4'b0001);
        tick;
        b1.acc_ydata = 32'hBEEF_0001; #1;
        chk("fl_rsp1", {b1.port_yvalid, b1.cache_control_valid}, {4'b0010, 1'b0});
        tick;
        b1.acc_yvalid = 0; #1;
        chk("fl_drained_nocc", b1.cache_control_valid, 0);
        tick;
        chk("fl_issue", {b1.cache_control_valid, b1.cache_control_last}, {1'b1, 32'h0000_1FFF});
        b1.cache_control_busy = 1;
        tick;
        chk("wait1", {b1.cache_control_valid, b1.ctrl_done}, 0);
        tick;
        chk("wait2", b1.ctrl_done, 0);
        tick;
        chk("wait3", b1.ctrl_done, 0);
        b1.cache_control_busy = 0; #1;
        chk("ctrl_done", b1.ctrl_done, 1);
        tick;
        chk("done_pulse", {b1.ctrl_done, b1.busy}, 0);

        // reset while waiting on the cache
        b1.ctrl_valid = 1; b1.ctrl_cmd = 4'hA;
        tick;
        b1.ctrl_valid = 0;
        tick;
        b1.cache_control_busy = 1;
        tick;
        chk("wait_state", {b1.busy, b1.ctrl_done, b1.cache_control_valid}, 3'b100);
        rstpp = 1;
        tick;
        chk("rst_wait_outs", {b1.acc_qvalid, b1.port_qready, b1.port_yvalid, b1.acc_yready, b1.ctrl_ready,
                              b1.ctrl_done, b1.cache_control_valid, b1.busy}, '0);
        chk("rst_wait_cmd", b1.cache_control_command, 0);
        rstpp = 0; b1.cache_control_busy = 0; #1;
        chk("rst_idle_nodone", {b1.ctrl_done, b1.cache_control_valid}, 0);

        // reset with three reads outstanding and a grant pending
        b1.port_qvalid = 4'b0111;
        repeat (6) tick;
        b1.acc_qready = 0;
        tick;
        chk("pend3", {b1.acc_qvalid, b1.acc_qaddr, b1.busy}, {1'b1, addr_of(0), 1'b1});
        b1.port_qvalid = '0; b1.ctrl_valid = 1;
        tick;
        b1.ctrl_valid = 0; #1;
        chk("drain3", {b1.acc_qvalid, b1.cache_control_valid, b1.busy}, 3'b101);
        rstpp = 1;
        tick;
        chk("rst_fifo_outs", {b1.acc_qvalid, b1.port_qready, b1.port_yvalid, b1.ctrl_ready,
                              b1.cache_control_valid, b1.busy}, '0);
        rstpp = 0;
        b1.acc_yvalid = 1; #1;
        chk("rst_drop", {b1.port_yvalid, b1.acc_yready}, 5'b00001);
        tick;
        b1.acc_yvalid = 0; #1;
        chk("rst_drop_idle", b1.busy, 0);

        // fixed priority: port 1 beats port 3 until it drops
        for (int i = 0; i < NP; i++) b2.port_qaddr[i] = addr_of(i) + 32'h100;
        b2.port_qvalid = 4'b1010; b2.acc_qready = 1; b2.acc_yvalid = 1;
        b2.acc_ydata = 32'h5A5A_0001; b2.port_yready = 4'hF;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("fp_port1", {b2.port_qready, b2.acc_qaddr}, {4'b0010, addr_of(1) + 32'h100});
            tick;
        end
        b2.port_qvalid = 4'b1000;
        tick;
        chk("fp_port3", {b2.port_qready, b2.acc_qaddr}, {4'b1000, addr_of(3) + 32'h100});
        tick;
        b2.port_qvalid = '0;
        tick;
        b2.acc_yvalid = 0; #1;
        chk("fp_idle", b2.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
